spwm_phase_scheduler: RTL

Time-multiplexes the single registered half-wave sine look-up table across three phase channels (A, B, C, 120° apart) for the SPWM generator. On each sample tick it advances a phase accumulator, issues three table addresses back to back, and folds the half-wave table into bipolar magnitude plus sign. It then commits all three references to the PWM comparators in one cycle. It sits between the sample-rate timebase and the comparator stage, and owns the LUT address bus exclusively.

---
 rtl/spwm_phase_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/spwm_phase_scheduler.sv
// Shares one registered half-wave sine LUT across three 120-degree phase channels for SPWM.
// Optional synchronous accumulator clear input phase_clr under `define SPWM_SCHED_PHASE_CLR_EN.
module spwm_phase_scheduler #(
    parameter int ACC_W       = 16,
    parameter int PHASE_B_OFS = 85,
    parameter int PHASE_C_OFS = 171
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             run,
`ifdef SPWM_SCHED_PHASE_CLR_EN
    input  logic             phase_clr,
`endif
    input  logic [ACC_W-1:0] freq_word,
    output logic [7:0]       lut_addr,
    input  logic [11:0]      lut_data,
    output logic [11:0]      ref_a,
    output logic [11:0]      ref_b,
    output logic [11:0]      ref_c,
    output logic             neg_a,
    output logic             neg_b,
    output logic             neg_c,
    output logic             ref_valid,
    output logic             busy,
    output logic             overrun
);

    localparam logic [7:0] OFS_B = 8'(PHASE_B_OFS);
    localparam logic [7:0] OFS_C = 8'(PHASE_C_OFS);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_A,
        ADDR_B,
        ADDR_C,
        WAIT,
        COMMIT
    } state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [7:0]       p_a_nxt;
    logic [7:0]       p_a, p_b, p_c;
    logic [11:0]      sh_a, sh_b;
    logic [7:0]       addr_nxt;
    logic             clr_req;
    logic             accept;
    logic             drop;
    logic             ld_addr;
    logic             cap_a;
    logic             cap_b;
    logic             commit;

`ifdef SPWM_SCHED_PHASE_CLR_EN
    assign clr_req = phase_clr;
`else
    assign clr_req = 1'b0;
`endif

    assign acc_sum = acc + freq_word;
    assign p_a_nxt = acc_sum[ACC_W-1 -: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ld_addr   = 1'b0;
        addr_nxt  = lut_addr;
        cap_a     = 1'b0;
        cap_b     = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                // A tick coincident with phase_clr is consumed without starting a sweep.
                if (tick && run && !clr_req) begin
                    accept    = 1'b1;
                    state_nxt = ADDR_A;
                end
            end
            ADDR_A: begin
                ld_addr   = 1'b1;
                addr_nxt  = {1'b0, p_a[6:0]};
                state_nxt = ADDR_B;
            end
            ADDR_B: begin
                ld_addr   = 1'b1;
                addr_nxt  = {1'b0, p_b[6:0]};
                state_nxt = ADDR_C;
            end
            ADDR_C: begin
                ld_addr   = 1'b1;
                addr_nxt  = {1'b0, p_c[6:0]};
                cap_a     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                cap_b     = 1'b1;
                state_nxt = COMMIT;
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign drop = tick && run && (state != IDLE);
    assign busy = (state != IDLE) || ref_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            p_a       <= '0;
            p_b       <= '0;
            p_c       <= '0;
            lut_addr  <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            ref_a     <= '0;
            ref_b     <= '0;
            ref_c     <= '0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            neg_c     <= 1'b0;
            ref_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (clr_req) begin
                acc <= '0;
            end else if (accept) begin
                acc <= acc_sum;
            end
            if (accept) begin
                p_a <= p_a_nxt;
                p_b <= p_a_nxt + OFS_B;
                p_c <= p_a_nxt + OFS_C;
            end
            if (ld_addr) begin
                lut_addr <= addr_nxt;
            end
            if (cap_a) begin
                sh_a <= lut_data;
            end
            if (cap_b) begin
                sh_b <= lut_data;
            end
            ref_valid <= commit;
            // Channel C arrives on the commit edge itself, so it bypasses the shadows.
            if (commit) begin
                ref_a <= sh_a;
                ref_b <= sh_b;
                ref_c <= lut_data;
                neg_a <= p_a[7];
                neg_b <= p_b[7];
                neg_c <= p_c[7];
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
